// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl
// Registered front end of the immediate datapath. It accepts 32-bit
// instructions over a valid/ready handshake and classifies each one as a
// load, store or branch. It produces the sign-extended immediate and the
// format select, and holds them in a one-entry output buffer. An
// unsupported opcode is captured and traps the block until trap_clr.
//
// Build option: define IMM_DECODE_CNT_EN to implement the saturating
// per-class accept counters. Without it, cnt_* are tied to zero.
//
// state | meaning
// IDLE  | buffer empty, ready for an instruction
// FULL  | buffer holds a decoded result (out_valid)
// TRAP  | unsupported opcode captured, waiting for trap_clr

module imm_decode_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       imm_sel,
    output logic [XLEN-1:0]  imm_value,
    output logic             is_load,
    output logic             is_store,
    output logic             is_branch,
    output logic             trap,
    output logic [31:0]      trap_instr,
    input  logic             trap_clr,
    output logic [CNT_W-1:0] cnt_load,
    output logic [CNT_W-1:0] cnt_store,
    output logic [CNT_W-1:0] cnt_branch
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FULL = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t state;

    logic            dec_load;
    logic            dec_store;
    logic            dec_branch;
    logic            dec_legal;
    logic [1:0]      dec_sel;
    logic [11:0]     dec_imm12;
    logic [XLEN-1:0] dec_imm;
    logic            accept;

    // Opcode classification and immediate extraction for the incoming word.
    // The B-type immediate is the 12-bit half-offset; the branch adder does the shift.
    always_comb begin
        dec_load   = (instruction[6:0] == OP_LOAD);
        dec_store  = (instruction[6:0] == OP_STORE);
        dec_branch = (instruction[6:0] == OP_BRANCH);
        dec_legal  = dec_load | dec_store | dec_branch;
        dec_sel    = 2'b00;
        dec_imm12  = instruction[31:20];
        if (dec_store) begin
            dec_sel   = 2'b01;
            dec_imm12 = {instruction[31:25], instruction[11:7]};
        end else if (dec_branch) begin
            dec_sel   = 2'b10;
            dec_imm12 = {instruction[31], instruction[7], instruction[30:25], instruction[11:8]};
        end
    end

    assign dec_imm     = {{(XLEN-12){instruction[31]}}, dec_imm12};

    // Ready depends only on state and downstream drain, never on instr_valid.
    assign instr_ready = (state == IDLE) | ((state == FULL) & out_ready);
    assign accept      = instr_valid & instr_ready;
    assign out_valid   = (state == FULL);
    assign trap        = (state == TRAP);

    // Control FSM plus result buffer and trap capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            imm_sel    <= 2'b00;
            imm_value  <= '0;
            is_load    <= 1'b0;
            is_store   <= 1'b0;
            is_branch  <= 1'b0;
            trap_instr <= '0;
        end else if (accept) begin
            if (dec_legal) begin
                state     <= FULL;
                imm_sel   <= dec_sel;
                imm_value <= dec_imm;
                is_load   <= dec_load;
                is_store  <= dec_store;
                is_branch <= dec_branch;
            end else begin
                state      <= TRAP;
                trap_instr <= instruction;
            end
        end else if ((state == FULL) && out_ready) begin
            state <= IDLE;
        end else if ((state == TRAP) && trap_clr) begin
            state <= IDLE;
        end
    end

`ifdef IMM_DECODE_CNT_EN
    // Saturating per-class counters of legally accepted instructions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_load   <= '0;
            cnt_store  <= '0;
            cnt_branch <= '0;
        end else if (accept) begin
            if (dec_load && (cnt_load != '1))
                cnt_load <= cnt_load + CNT_W'(1);
            if (dec_store && (cnt_store != '1))
                cnt_store <= cnt_store + CNT_W'(1);
            if (dec_branch && (cnt_branch != '1))
                cnt_branch <= cnt_branch + CNT_W'(1);
        end
    end
`else
    assign cnt_load   = '0;
    assign cnt_store  = '0;
    assign cnt_branch = '0;
`endif

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Directed bench for imm_decode_ctrl with hand-computed expected values.
// The DUT is built with CNT_W=2 so that counter saturation is reachable.
// Counter expectations scale to zero when IMM_DECODE_CNT_EN is undefined.

module tb_imm_decode_ctrl;

    localparam int XLEN  = 64;
    localparam int CNT_W = 2;
`ifdef IMM_DECODE_CNT_EN
    localparam int CE = 1;
`else
    localparam int CE = 0;
`endif

    localparam logic [31:0] I_LD   = 32'hFF813283;
    localparam logic [31:0] I_SD   = 32'h00513823;
    localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
    localparam logic [31:0] I_ADDI = 32'h00000013;

    localparam logic [63:0] IMM_LD  = 64'hFFFFFFFFFFFFFFF8;
    localparam logic [63:0] IMM_SD  = 64'h0000000000000010;
    localparam logic [63:0] IMM_BEQ = 64'hFFFFFFFFFFFFFFFE;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instruction;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       imm_sel;
    logic [XLEN-1:0]  imm_value;
    logic             is_load, is_store, is_branch;
    logic             trap;
    logic [31:0]      trap_instr;
    logic             trap_clr;
    logic [CNT_W-1:0] cnt_load, cnt_store, cnt_branch;

    int n_chk = 0;
    int n_err = 0;

    imm_decode_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .imm_sel     (imm_sel),
        .imm_value   (imm_value),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_branch   (is_branch),
        .trap        (trap),
        .trap_instr  (trap_instr),
        .trap_clr    (trap_clr),
        .cnt_load    (cnt_load),
        .cnt_store   (cnt_store),
        .cnt_branch  (cnt_branch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [1:0] sel, input logic [63:0] imm,
                                input logic [2:0] cls);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".imm_sel"},   64'(imm_sel),   64'(sel));
        check({tag, ".imm_value"}, imm_value,      imm);
        check({tag, ".class"},     64'({is_load, is_store, is_branch}), 64'(cls));
    endtask

    task automatic check_counts(input string tag, input int l, input int s, input int b);
        check({tag, ".cnt_load"},   64'(cnt_load),   64'(l * CE));
        check({tag, ".cnt_store"},  64'(cnt_store),  64'(s * CE));
        check({tag, ".cnt_branch"}, 64'(cnt_branch), 64'(b * CE));
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".instr_ready"}, 64'(instr_ready), 64'd1);
        check({tag, ".out_valid"},   64'(out_valid),   64'd0);
        check({tag, ".imm_sel"},     64'(imm_sel),     64'd0);
        check({tag, ".imm_value"},   imm_value,        64'd0);
        check({tag, ".class"},       64'({is_load, is_store, is_branch}), 64'd0);
        check({tag, ".trap"},        64'(trap),        64'd0);
        check({tag, ".trap_instr"},  64'(trap_instr),  64'd0);
        check_counts(tag, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instruction = '0;
        out_ready   = 1'b1;
        trap_clr    = 1'b0;
        step();
        step();
        check_reset("reset");
        rst_n = 1'b1;

        // Single decodes with downstream always ready.
        instr_valid = 1'b1; instruction = I_LD;
        step();
        instr_valid = 1'b0;
        check_result("load", 2'b00, IMM_LD, 3'b100);
        check_counts("load", 1, 0, 0);
        step();
        check("load.drain", 64'(out_valid), 64'd0);
        check("load.hold_sel", 64'(imm_sel), 64'd0);

        instr_valid = 1'b1; instruction = I_SD;
        step();
        instr_valid = 1'b0;
        check_result("store", 2'b01, IMM_SD, 3'b010);
        check_counts("store", 1, 1, 0);

        instr_valid = 1'b1; instruction = I_BEQ;
        step();
        instr_valid = 1'b0;
        check_result("branch", 2'b10, IMM_BEQ, 3'b001);
        check_counts("branch", 1, 1, 1);
        step();
        check("branch.drain", 64'(out_valid), 64'd0);

        // Backpressure: first result must hold for three stalled cycles.
        out_ready   = 1'b0;
        instr_valid = 1'b1; instruction = I_LD;
        step();
        instruction = I_SD;
        for (int i = 0; i < 3; i++) begin
            check_result($sformatf("stall%0d", i), 2'b00, IMM_LD, 3'b100);
            check($sformatf("stall%0d.instr_ready", i), 64'(instr_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("release.instr_ready", 64'(instr_ready), 64'd1);
        step();
        check_result("stream.store", 2'b01, IMM_SD, 3'b010);
        instruction = I_BEQ;
        step();
        check_result("stream.branch", 2'b10, IMM_BEQ, 3'b001);
        instr_valid = 1'b0;
        step();
        check("stream.drain", 64'(out_valid), 64'd0);
        check_counts("stream", 2, 2, 2);

        // Unsupported opcode traps until cleared.
        instr_valid = 1'b1; instruction = I_ADDI;
        step();
        instr_valid = 1'b0;
        check("trap.flag", 64'(trap), 64'd1);
        check("trap.instr", 64'(trap_instr), 64'(I_ADDI));
        check("trap.instr_ready", 64'(instr_ready), 64'd0);
        check("trap.out_valid", 64'(out_valid), 64'd0);
        check("trap.class_hold", 64'({is_load, is_store, is_branch}), 64'b001);
        check_counts("trap", 2, 2, 2);
        instr_valid = 1'b1; instruction = I_LD;
        step();
        instr_valid = 1'b0;
        check("trap.persist", 64'(trap), 64'd1);
        check("trap.no_accept", 64'(out_valid), 64'd0);
        trap_clr = 1'b1;
        step();
        trap_clr = 1'b0;
        check("clr.trap", 64'(trap), 64'd0);
        check("clr.instr_ready", 64'(instr_ready), 64'd1);
        instr_valid = 1'b1; instruction = I_LD;
        step();
        instr_valid = 1'b0;
        check_result("postclr.load", 2'b00, IMM_LD, 3'b100);
        check_counts("postclr", 3, 2, 2);

        // trap_clr while FULL has no effect.
        out_ready = 1'b0; trap_clr = 1'b1;
        step();
        trap_clr = 1'b0;
        check("clr_ignored.out_valid", 64'(out_valid), 64'd1);
        check("clr_ignored.trap", 64'(trap), 64'd0);

        // Reset while FULL discards everything.
        rst_n = 1'b0;
        step();
        check_reset("midreset");
        rst_n = 1'b1; out_ready = 1'b1;

        // Five back-to-back loads saturate a 2-bit counter at 3.
        instr_valid = 1'b1; instruction = I_LD;
        for (int i = 0; i < 5; i++) step();
        instr_valid = 1'b0;
        check_result("sat.load", 2'b00, IMM_LD, 3'b100);
        check_counts("sat", 3, 0, 0);
        step();
        check("sat.drain", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/imm_decode_ctrl.md
Name: imm_decode_ctrl

Overview:
- Registered front-end controller for the immediate datapath.
- Accepts 32-bit instructions over a valid/ready handshake and classifies the opcode as load, store or branch.
- Drives the 2-bit immediate-format select and produces the registered, sign-extended immediate together with the select and class flags.
- Holds results in a one-entry output buffer with backpressure, and traps on unsupported opcodes until software/bench clears the trap.

Parameters:
- XLEN, 64, width of the sign-extended immediate.
- CNT_W, 16, width of each per-class instruction counter (saturating).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- instr_valid  in  1  upstream has an instruction
- instr_ready  out  1  block can accept an instruction this cycle
- instruction  in  32  instruction word, sampled when instr_valid & instr_ready
- out_valid  out  1  output buffer holds a decoded result
- out_ready  in  1  downstream consumes the result this cycle
- imm_sel  out  2  00 = I (load), 01 = S (store), 10 = B (branch)
- imm_value  out  XLEN  sign-extended immediate
- is_load / is_store / is_branch  out  1 each  one-hot class of the buffered result
- trap  out  1  unsupported opcode captured
- trap_instr  out  32  offending instruction word
- trap_clr  in  1  clears the trap state
- cnt_load / cnt_store / cnt_branch  out  CNT_W each  accepted-instruction counters (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a clock edge) forces:
  - state = IDLE
  - instr_ready=1 after reset
  - out_valid=0, imm_sel=00, imm_value=0, all class flags 0
  - trap=0, trap_instr=0, counters 0
- Reset mid-operation discards any buffered result or trap.
- Accept: instr_valid & instr_ready on a clock edge.
- Format decode, on opcode bits [6:0]:
  - 0000011 → I-type: imm_sel=00, imm = sext(instr[31:20]).
  - 0100011 → S-type: imm_sel=01, imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 → B-type: imm_sel=10, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8]}).
  - B-type is the 12-bit half-offset with no appended zero; the branch adder applies the shift.
  - Any other opcode is illegal.
- Sign extension replicates instr[31] into bits XLEN-1:12.
- Latency: one cycle from accept to out_valid=1 with result fields valid.
- States:
  - IDLE:
    - instr_ready=1, out_valid=0.
    - Legal accept → FULL.
    - Illegal accept → TRAP: trap_instr=instruction, trap=1.
  - FULL:
    - out_valid=1; result fields stable while out_valid & !out_ready.
    - instr_ready = out_ready (pass-through when downstream drains).
    - out_ready & legal accept: load new result, stay FULL (back-to-back, one per cycle).
    - out_ready & illegal accept: → TRAP; out_valid drops next cycle.
    - out_ready, no accept: → IDLE.
    - !out_ready: hold; instr_ready=0.
  - TRAP:
    - instr_ready=0, out_valid=0, trap=1, trap_instr held.
    - trap_clr=1 → IDLE next cycle (trap=0).
    - trap_clr outside TRAP is ignored.
- Class flags and imm_sel are updated only on a legal accept; they hold their last value when out_valid=0.
- Counters:
  - Increment by 1 on each legal accept of their class.
  - Saturate at 2^CNT_W-1; never wrap.
  - Illegal opcodes are not counted.
- instr_ready is combinational from state and out_ready only (never from instr_valid).

Optional Feature:
- Macro: IMM_DECODE_CNT_EN.
- Defined: counters implemented as above.
- Undefined: counter registers are omitted, and cnt_load/cnt_store/cnt_branch are tied to 0. All other behaviour is identical.

Test Plan:
- Load decode: reset, then send 0xFF813283 (ld x5,-8(x2)) → next cycle out_valid=1, imm_sel=00, imm_value=0xFFFFFFFFFFFFFFF8, is_load=1, cnt_load=1.
- Store decode: send 0x00513823 (sd x5,16(x2)) → imm_sel=01, imm_value=0x10, is_store=1.
- Branch decode: send 0xFE000EE3 (beq x0,x0,-4) → imm_sel=10, imm_value=0xFFFFFFFFFFFFFFFE, is_branch=1.
- Backpressure/streaming:
  - Stream load, store, branch with out_ready=0 for 3 cycles after the first result → first result held stable, instr_ready=0 during the stall.
  - On release, one result per cycle in order; no loss or duplication.
- Trap: send 0x00000013 (addi) → trap=1, trap_instr=0x00000013, instr_ready=0, out_valid=0, counters unchanged. Pulse trap_clr → IDLE, next legal instruction decodes normally.
- Reset/saturation:
  - Assert rst_n=0 while FULL → all outputs return to reset values next edge.
  - With CNT_W=2 and IMM_DECODE_CNT_EN defined, 5 loads → cnt_load=3.
